// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS fetch stage and its control-unit neighbours.
package fetch_pkg;

    localparam int OPC_W = 6;
    localparam int JT_W  = 26;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OPC_J     = 6'b000010;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select for the consumed instruction: jump > taken branch > sequential.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [31:0]     pc_plus4,
    input  logic            branch_taken,
    input  logic [31:0]     branch_offset,
    input  logic            jump,
    input  logic [JT_W-1:0] jump_target,
    output logic [31:0]     next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + (branch_offset << 2);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch: PC, imem req/ack handshake, held instruction for decode.
// Optional perf counters (perf_fetched, perf_stall) under `FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ack,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_offset,
    input  logic             jump,
    input  logic [JT_W-1:0]  jump_target,
    output logic [31:0]      instr,
    output logic [OPC_W-1:0] opcode,
    output logic [31:0]      pc_plus4,
    output logic             instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stall
`endif
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  r_pc_plus4;
    logic         r_instr_valid;
    logic         r_imem_req;
    logic [31:0]  w_next_pc;
    logic         w_consume;

    assign w_consume = (r_state == ST_HOLD) && !stall;

    fetch_next_pc u_next_pc (
        .pc_plus4      (r_pc_plus4),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .next_pc       (w_next_pc)
    );

    // imem_ack only matters in REQ, so a response in flight across reset lands in IDLE and is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_pc_plus4    <= '0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_REQ;
                    r_imem_req <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_pc_plus4    <= r_pc + 32'd4;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= ST_REQ;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:32-OPC_W];
    assign pc_plus4    = r_pc_plus4;
    assign instr_valid = r_instr_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_consume) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (r_instr_valid && stall) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the MIPS datapath. Holds the program counter, requests instructions from instruction memory over a request/acknowledge handshake, and presents the fetched word with its opcode field to the decode/control stage. It then holds that instruction until decode consumes it. On consumption it computes the next PC (sequential, branch or jump) from the redirect information that decode and the ALU return for the consumed instruction.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Must be word aligned.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  fetch address; always equal to `pc`.
- `imem_rdata`  in  32  instruction word; valid only when `imem_ack`=1.
- `imem_ack`  in  1  memory response valid. May arrive in the same cycle as `imem_req` or any later cycle.
- `stall`  in  1  decode not ready; blocks consumption.
- `branch_taken`  in  1  the consumed instruction is a branch and its condition is true (branch & zero).
- `branch_offset`  in  32  sign-extended 16-bit immediate of the consumed instruction.
- `jump`  in  1  the consumed instruction is a jump.
- `jump_target`  in  26  instr[25:0] of the consumed instruction.
- `instr`  out  32  held instruction.
- `opcode`  out  6  `instr[31:26]`; drives the control unit.
- `pc_plus4`  out  32  address of the held instruction + 4.
- `instr_valid`  out  1  `instr`/`opcode`/`pc_plus4` are valid.

## Operation
States:
- IDLE: entered on reset; lasts exactly one cycle, then goes to REQ.
- REQ: `imem_req`=1. On `imem_ack`=1, capture `instr`<=`imem_rdata` and `pc_plus4`<=`pc`+4, then go to HOLD. Otherwise stay in REQ, with `imem_addr` held stable.
- HOLD: `instr_valid`=1. Consume occurs when `stall`=0. On consume, `pc`<=next PC and the FSM goes to REQ. While `stall`=1, all outputs are frozen.

Next PC, evaluated only at consume; priority is highest first:
- `jump`: {`pc_plus4`[31:28], `jump_target`, 2'b00}.
- `branch_taken`: `pc_plus4` + (`branch_offset` << 2). 32-bit modular arithmetic; overflow wraps silently.
- otherwise: `pc_plus4`.

Boundary conditions:
- `jump` and `branch_taken` both high (the control unit asserts branch together with jump for `j`): jump wins.
- Redirect inputs are ignored outside a consume cycle.
- `imem_ack` is ignored in IDLE and HOLD.
- A stale ack arriving after a reset is discarded.
- PC 32'hFFFF_FFFC sequential: `pc_plus4` = 0; fetch continues at 0.
- Reset asserted mid-REQ or mid-HOLD: immediate return to IDLE. A pending memory response is dropped.

Reset values:
- `pc` = `RESET_PC`, state IDLE.
- `imem_req`=0, `imem_addr`=`RESET_PC`.
- `instr`=0, `opcode`=0, `pc_plus4`=0, `instr_valid`=0.
- Perf counters = 0.

## Timing
- Reset release to first `imem_req`: 1 cycle (the IDLE cycle).
- Ack to `instr_valid`: `instr_valid` rises on the edge that samples `imem_ack`.
- Consume edge to next `imem_req`: `imem_req` is high in the cycle immediately after the consume edge.
- Best-case throughput: one instruction per 2 cycles (REQ+HOLD), with a zero-wait memory and `stall`=0.
- `imem_addr` changes only on a consume edge or on reset.
- `opcode` is purely a slice of the registered `instr`; there is no extra delay.

## Configuration
- Macro `FETCH_PERF_CNT_EN` defined: adds two 32-bit outputs.
  - `perf_fetched`: increments on each consume.
  - `perf_stall`: increments on each cycle with `instr_valid`=1 and `stall`=1.
  - Both wrap modulo 2^32 and are cleared by `rst_n`.
- Macro not defined: neither the ports nor the counter logic exist; behaviour is otherwise identical.

## Structure
- Package `fetch_pkg`:
  - FSM state encoding (IDLE/REQ/HOLD).
  - Opcode width (6) and jump-target width (26).
  - Opcode constants shared with the control unit (R-type 6'b000000, beq 6'b000100, j 6'b000010).
- Sub-module `fetch_next_pc`: purely combinational next-PC selector, with inputs `pc_plus4`, `branch_taken`, `branch_offset`, `jump`, `jump_target`. It is instantiated once.

## Test plan
- Reset with `RESET_PC`=32'h0000_0040 and zero-wait ack:
  - first `imem_addr`=0x40.
  - `instr_valid` set with `pc_plus4`=0x44.
  - With no redirect and no stall, the next fetch is at 0x44.
- Ack delayed 3 cycles:
  - `imem_req` stays 1 and `imem_addr` stays stable for 4 cycles.
  - `instr`=`imem_rdata` captured at the ack edge.
- `stall`=1 for 5 cycles in HOLD:
  - outputs are frozen and no new request is made.
  - `perf_stall`=5 when the macro is defined.
- Branch at PC 0x100 with `branch_offset`=32'hFFFF_FFFE: next fetch 0x0FC.
- Jump and `branch_taken` together with `pc_plus4`=0x1000_0008 and `jump_target`=26'h000_0010: next fetch 0x1000_0040.
- Reset asserted during REQ, with an ack in the following cycle:
  - ack ignored; `instr_valid`=0.
  - fetch restarts at `RESET_PC` after one IDLE cycle.
